// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan chain controller.
// Holds the controller state encoding, the per-design slot width and a helper
// that maps a chain position onto the currently targeted design slot.
package scan_ctrl_pkg;

    localparam int unsigned BITS_PER_DESIGN = 8;

    typedef enum logic [2:0] {
        StIdle,
        StShiftIn,
        StLatch,
        StCapture,
        StShiftOut,
        StDone
    } scan_state_e;

    // True when chain position pos lies inside slot sel and that slot exists.
    function automatic logic slot_hit(input int unsigned pos, input int unsigned sel,
                                      input int unsigned num_designs);
        return (sel < num_designs) && ((pos / BITS_PER_DESIGN) == sel);
    endfunction

endpackage

// File: rtl/scan_bit_counter.sv
// Bit/phase sequencer for the scan chain controller.
// Each chain bit spans two enabled cycles: phase 0 (low) then phase 1 (high).
// The bit index advances after the high phase and stops at LEN-1, so it never
// wraps inside a phase; the controller clears it between phases.
// Ports:
//   clk, resetb  - clock, synchronous active-low reset
//   clear        - return phase and index to zero (wins over enable)
//   enable       - advance the sequence by one cycle
//   phase        - 0 = low half of the bit, 1 = high half
//   index        - current bit index, 0..LEN-1
//   last         - high phase of bit LEN-1
module scan_bit_counter #(
    parameter int unsigned LEN = 32,
    localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             clear,
    input  logic             enable,
    output logic             phase,
    output logic [IDX_W-1:0] index,
    output logic             last
);

    logic             phase_q, phase_d;
    logic [IDX_W-1:0] index_q, index_d;

    assign last  = phase_q && (index_q == IDX_W'(LEN - 1));
    assign phase = phase_q;
    assign index = index_q;

    always_comb begin
        phase_d = phase_q;
        index_d = index_q;
        if (clear) begin
            phase_d = 1'b0;
            index_d = '0;
        end else if (enable) begin
            phase_d = ~phase_q;
            if (phase_q && !last) begin
                index_d = index_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            phase_q <= 1'b0;
            index_q <= '0;
        end else begin
            phase_q <= phase_d;
            index_q <= index_d;
        end
    end

endmodule

// File: rtl/scan_chain_controller.sv
// Scan chain controller: runs one full shift-in / latch / capture / shift-out
// transaction on an external chain of NUM_DESIGNS 8-bit design slots.
// Every output is registered, so pins follow the internal state one cycle late.
// Ports:
//   clk, resetb     - clock, synchronous active-low reset
//   start           - request a transaction (honoured only when idle)
//   active_select   - target slot, sampled with start
//   inputs          - byte for the target slot, sampled with start
//   scan_data_in    - serial data returning from the end of the chain
//   scan_clk        - chain shift clock
//   scan_data_out   - serial data into the chain
//   scan_select     - 1 = chain captures design outputs, 0 = chain shifts
//   scan_latch_en   - latch chain contents onto the design inputs
//   outputs         - captured byte of the target slot, held between runs
//   busy            - transaction in progress
//   valid           - one-cycle pulse when outputs update
module scan_chain_controller
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DESIGNS = 4,
    parameter int unsigned SEL_W       = 2
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             start,
    input  logic [SEL_W-1:0] active_select,
    input  logic [7:0]       inputs,
    input  logic             scan_data_in,
    output logic             scan_clk,
    output logic             scan_data_out,
    output logic             scan_select,
    output logic             scan_latch_en,
    output logic [7:0]       outputs,
    output logic             busy,
    output logic             valid
);

    localparam int unsigned CHAIN_LEN = BITS_PER_DESIGN * NUM_DESIGNS;
    localparam int unsigned IDX_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int unsigned BIT_W     = $clog2(BITS_PER_DESIGN);

    scan_state_e      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       in_q, in_d;
    logic [7:0]       cap_q, cap_d;

    logic             scan_clk_q, scan_clk_d;
    logic             scan_data_out_q, scan_data_out_d;
    logic             scan_select_q, scan_select_d;
    logic             scan_latch_en_q, scan_latch_en_d;
    logic [7:0]       outputs_q, outputs_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             cnt_clear, cnt_enable, cnt_phase, cnt_last;
    logic [IDX_W-1:0] cnt_index;
    logic [IDX_W-1:0] pos;
    logic             hit;

    scan_bit_counter #(
        .LEN(CHAIN_LEN)
    ) u_bit_counter (
        .clk   (clk),
        .resetb(resetb),
        .clear (cnt_clear),
        .enable(cnt_enable),
        .phase (cnt_phase),
        .index (cnt_index),
        .last  (cnt_last)
    );

    // Shift index j addresses chain position L-1-j in both shift directions.
    assign pos = IDX_W'(CHAIN_LEN - 1) - cnt_index;
    assign hit = slot_hit(32'(pos), 32'(sel_q), NUM_DESIGNS);

    // Next-state, operand capture and deserializer.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        in_d       = in_q;
        cap_d      = cap_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StShiftIn;
                    sel_d     = active_select;
                    in_d      = inputs;
                    cap_d     = '0;
                    cnt_clear = 1'b1;
                end
            end
            StShiftIn: begin
                cnt_enable = 1'b1;
                if (cnt_last) begin
                    state_d   = StLatch;
                    cnt_clear = 1'b1;
                end
            end
            StLatch: begin
                cnt_enable = 1'b1;
                if (cnt_phase) begin
                    state_d   = StCapture;
                    cnt_clear = 1'b1;
                end
            end
            StCapture: begin
                cnt_enable = 1'b1;
                if (cnt_phase) begin
                    state_d   = StShiftOut;
                    cnt_clear = 1'b1;
                end
            end
            StShiftOut: begin
                cnt_enable = 1'b1;
                // Sample in the low phase, before the next scan_clk rise moves the chain.
                if (!cnt_phase && hit) begin
                    cap_d[pos[BIT_W-1:0]] = scan_data_in;
                end
                if (cnt_last) begin
                    state_d   = StDone;
                    cnt_clear = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pin values for the current state; registered below.
    always_comb begin
        scan_clk_d      = 1'b0;
        scan_data_out_d = 1'b0;
        scan_select_d   = 1'b0;
        scan_latch_en_d = 1'b0;
        valid_d         = 1'b0;
        outputs_d       = outputs_q;
        busy_d          = (state_q != StIdle);
        unique case (state_q)
            StShiftIn: begin
                scan_clk_d      = cnt_phase;
                scan_data_out_d = hit & in_q[pos[BIT_W-1:0]];
            end
            StLatch: begin
                scan_latch_en_d = ~cnt_phase;
            end
            StCapture: begin
                scan_select_d = 1'b1;
                scan_clk_d    = cnt_phase;
            end
            StShiftOut: begin
                scan_clk_d = cnt_phase;
            end
            StDone: begin
                valid_d   = 1'b1;
                outputs_d = cap_q;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q         <= StIdle;
            sel_q           <= '0;
            in_q            <= '0;
            cap_q           <= '0;
            scan_clk_q      <= 1'b0;
            scan_data_out_q <= 1'b0;
            scan_select_q   <= 1'b0;
            scan_latch_en_q <= 1'b0;
            outputs_q       <= '0;
            busy_q          <= 1'b0;
            valid_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            in_q            <= in_d;
            cap_q           <= cap_d;
            scan_clk_q      <= scan_clk_d;
            scan_data_out_q <= scan_data_out_d;
            scan_select_q   <= scan_select_d;
            scan_latch_en_q <= scan_latch_en_d;
            outputs_q       <= outputs_d;
            busy_q          <= busy_d;
            valid_q         <= valid_d;
        end
    end

    assign scan_clk      = scan_clk_q;
    assign scan_data_out = scan_data_out_q;
    assign scan_select   = scan_select_q;
    assign scan_latch_en = scan_latch_en_q;
    assign outputs       = outputs_q;
    assign busy          = busy_q;
    assign valid         = valid_q;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: behavioural chain of four 8-bit designs
// (out = ~in), a stimulus process that queues expected transactions, and a
// monitor that checks pins, protocol and results against that queue.
module tb_scan_chain_controller;

    localparam int unsigned NUM     = 4;
    localparam int unsigned L       = 8 * NUM;
    localparam int unsigned TXN_CYC = 4 * L + 5;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       start = 1'b0;
    logic [1:0] active_select = 2'd0;
    logic [7:0] inputs = 8'h00;
    logic       scan_data_in;
    logic       scan_clk, scan_data_out, scan_select, scan_latch_en;
    logic [7:0] outputs;
    logic       busy, valid;

    always #5 clk = ~clk;

    scan_chain_controller #(
        .NUM_DESIGNS(NUM),
        .SEL_W      (2)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .start        (start),
        .active_select(active_select),
        .inputs       (inputs),
        .scan_data_in (scan_data_in),
        .scan_clk     (scan_clk),
        .scan_data_out(scan_data_out),
        .scan_select  (scan_select),
        .scan_latch_en(scan_latch_en),
        .outputs      (outputs),
        .busy         (busy),
        .valid        (valid)
    );

    // Chain model: position 0 is fed by scan_data_out, position L-1 returns.
    logic [L-1:0] chain = '0;
    logic [7:0]   des_in [NUM] = '{default: 8'h00};
    assign scan_data_in = chain[L-1];

    always @(posedge scan_clk) begin : chain_model
        logic [L-1:0] cv;
        if (scan_select) begin
            for (int d = 0; d < NUM; d++) cv[d*8 +: 8] = ~des_in[d];
            chain <= cv;
        end else begin
            chain <= {chain[L-2:0], scan_data_out};
        end
    end

    always @(negedge clk) begin
        if (scan_latch_en) begin
            for (int d = 0; d < NUM; d++) des_in[d] <= chain[d*8 +: 8];
        end
    end

    // Scoreboard
    typedef struct {
        int unsigned sel;
        logic [7:0]  din;
        logic [7:0]  dout;
        int unsigned start_cyc;
        int unsigned exp_cyc;
    } txn_t;

    txn_t        exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_out(input int unsigned sel, input logic [7:0] din);
        return (sel < NUM) ? ~din : 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    logic [7:0] hold_val = 8'h00;
    int         in_rises = 0, out_rises = 0, cap_rises = 0, latch_pulses = 0, sel_cycles = 0;
    logic       prev_sclk = 1'b0, prev_le = 1'b0;

    always @(posedge clk) begin : monitor
        txn_t e;
        logic busy_exp;
        #1;
        if (!resetb) begin
            exp_q.delete();
            hold_val     = 8'h00;
            in_rises     = 0;
            out_rises    = 0;
            cap_rises    = 0;
            latch_pulses = 0;
            sel_cycles   = 0;
            prev_sclk    = 1'b0;
            prev_le      = 1'b0;
            check("reset_outputs", 32'(outputs), 32'h0);
            check("reset_busy_valid", {30'd0, busy, valid}, 32'h0);
            check("reset_scan_pins",
                  {28'd0, scan_clk, scan_data_out, scan_select, scan_latch_en}, 32'h0);
        end else begin
            busy_exp = (exp_q.size() != 0) && (cyc > exp_q[0].start_cyc) &&
                       (cyc <= exp_q[0].exp_cyc);
            check("busy", 32'(busy), 32'(busy_exp));
            if (!busy_exp) begin
                check("idle_scan_pins",
                      {28'd0, scan_clk, scan_data_out, scan_select, scan_latch_en}, 32'h0);
            end
            if (scan_clk && !prev_sclk) begin
                if (scan_select)            cap_rises++;
                else if (latch_pulses == 0) in_rises++;
                else                        out_rises++;
            end
            if (scan_latch_en && !prev_le) latch_pulses++;
            if (scan_select) sel_cycles++;
            prev_sclk = scan_clk;
            prev_le   = scan_latch_en;

            if (valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_latency", cyc, e.exp_cyc);
                    check("outputs", 32'(outputs), 32'(e.dout));
                    for (int d = 0; d < NUM; d++) begin
                        check($sformatf("model_design%0d_in", d), 32'(des_in[d]),
                              (d == int'(e.sel)) ? 32'(e.din) : 32'h0);
                    end
                    check("shift_in_rises", in_rises, 32);
                    check("shift_out_rises", out_rises, 32);
                    check("capture_rises", cap_rises, 1);
                    check("latch_pulses", latch_pulses, 1);
                    check("select_cycles", sel_cycles, 2);
                    hold_val = e.dout;
                end
                in_rises     = 0;
                out_rises    = 0;
                cap_rises    = 0;
                latch_pulses = 0;
                sel_cycles   = 0;
            end else begin
                check("outputs_hold", 32'(outputs), 32'(hold_val));
                if (exp_q.size() != 0 && cyc > exp_q[0].exp_cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_timeout: got no valid, expected at cycle %0d",
                             exp_q[0].exp_cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus
    task automatic issue(input int unsigned sel, input logic [7:0] din, input bit expect_it);
        @(negedge clk);
        active_select = 2'(sel);
        inputs        = din;
        start         = 1'b1;
        if (expect_it) begin
            exp_q.push_back('{sel, din, ref_out(sel, din), cyc + 1, cyc + 1 + TXN_CYC});
        end
        @(negedge clk);
        // Scramble the operands so a controller that fails to hold them shows up.
        start         = 1'b0;
        active_select = 2'($urandom);
        inputs        = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < int'(TXN_CYC) + 20 && exp_q.size() != 0; i++) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        // Idle after reset: pins and outputs stay quiet.
        repeat (20) @(negedge clk);

        issue(2, 8'hA5, 1'b1);
        wait_idle();

        // Back-to-back, with a start during busy that must be ignored.
        issue(0, 8'h00, 1'b1);
        repeat (50) @(negedge clk);
        issue(2, 8'h77, 1'b0);
        wait_idle();
        issue(3, 8'hFF, 1'b1);
        wait_idle();

        // Abort mid-transaction, then a complete run.
        issue(1, 8'h81, 1'b1);
        repeat (39) @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        repeat (5) @(negedge clk);
        issue(1, 8'h3C, 1'b1);
        wait_idle();

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue($urandom_range(0, NUM - 1), 8'($urandom), 1'b1);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_chain_controller.md
SCAN_CHAIN_CONTROLLER -- requirements
Module: scan_chain_controller

Interface
REQ-001 Parameter NUM_DESIGNS, default 4, number of 8-bit design slots on the chain; chain length L = 8*NUM_DESIGNS.
REQ-002 Parameter SEL_W, default 2, width of the design-select input.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 resetb  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle request to run one full scan transaction.
REQ-006 active_select  input  SEL_W  target design slot; SHALL be sampled with start.
REQ-007 inputs  input  8  input byte for the target design; SHALL be sampled with start.
REQ-008 scan_data_in  input  1  return end of the chain; data from the last flop.
REQ-009 scan_clk  output  1  chain shift clock.
REQ-010 scan_data_out  output  1  serial data into the chain.
REQ-011 scan_select  output  1  1 = chain captures design outputs; 0 = chain shifts.
REQ-012 scan_latch_en  output  1  latches chain contents onto design inputs.
REQ-013 outputs  output  8  captured output byte of the target design.
REQ-014 busy  output  1  high from the cycle after start is accepted until DONE ends.
REQ-015 valid  output  1  single-cycle pulse; outputs are updated that cycle.

Function
REQ-016 States SHALL be IDLE, SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT and DONE; the block SHALL leave IDLE only on start.
REQ-017 start in IDLE SHALL move the FSM to SHIFT_IN and latch active_select and inputs; start in any other state SHALL be ignored.
REQ-018 Each chain bit SHALL take 2 clk cycles: a low phase (scan_clk=0, scan_data_out updated) then a high phase (scan_clk=1, data held).
REQ-019 SHIFT_IN SHALL shift exactly L bits (2L cycles). Shift index j (0..L-1) carries chain position p = L-1-j.
REQ-020 Position p = d*8+b SHALL carry inputs[b] when d equals the latched select; every other position SHALL carry 0.
REQ-021 LATCH SHALL last 2 cycles: scan_latch_en=1 in the first cycle and 0 in the second; scan_clk=0 throughout.
REQ-022 CAPTURE SHALL last 2 cycles with scan_select=1: scan_clk=0 in the first cycle and 1 in the second.
REQ-023 SHIFT_OUT SHALL shift L bits (2L cycles) with scan_data_out=0 and scan_select=0.
REQ-024 In the low phase of shift index j, the block SHALL sample scan_data_in as chain position L-1-j.
REQ-025 Samples from positions d*8..d*8+7 of the latched slot d SHALL be assembled into outputs[7:0], with position d*8+b going to bit b.
REQ-026 DONE SHALL last 1 cycle: it drives outputs, asserts valid, then returns to IDLE.
REQ-027 Latency: if start is sampled at edge N, valid SHALL be high in cycle N+4L+5; for L=32 that is N+133.
REQ-028 A latched select >= NUM_DESIGNS SHALL shift all-zero data, still run every phase, and give outputs=0x00 with valid.
REQ-029 outputs SHALL hold its value between transactions.
REQ-030 All outputs SHALL be registered with no combinational path from any input.
REQ-031 Bit and phase counters SHALL be sized for ceil(log2(L)) bits and SHALL never wrap within a phase.

Reset
REQ-032 When resetb=0 at a rising edge, the FSM SHALL go to IDLE and all counters SHALL clear to 0.
REQ-033 Reset values: scan_clk=0, scan_data_out=0, scan_select=0, scan_latch_en=0, outputs=0x00, busy=0, valid=0.
REQ-034 Reset SHALL take priority over start, including a start in the same cycle as reset.
REQ-035 Reset mid-transaction SHALL abort it with no valid pulse; the next start SHALL run a complete transaction.

Structure
REQ-036 Package scan_ctrl_pkg SHALL hold the state enum typedef and the constant BITS_PER_DESIGN=8.
REQ-037 Sub-module scan_bit_counter SHALL generate the phase toggle and the bit index, with inputs clear/enable and outputs phase, index and last.
REQ-038 The FSM, serializer and deserializer SHALL stay in scan_chain_controller.

Verification
REQ-039 The bench SHALL use a behavioural chain model: NUM_DESIGNS=4, each design computes out = ~in.
REQ-040 Reset then idle: outputs=0x00, busy=0, scan_clk stays 0 for 20 cycles.
REQ-041 start, select=2, inputs=0xA5: valid exactly 133 cycles later, outputs=0x5A; the model shows design 2 latched 0xA5 and all other designs 0x00.
REQ-042 Back-to-back transactions: select=0 with 0x00 -> 0xFF, then select=3 with 0xFF -> 0x00; start pulsed during busy is ignored, with no extra valid.
REQ-043 resetb low at cycle 40 of a transaction: no valid, outputs unchanged at 0x00; a following start, select=1 with 0x3C, gives 0xC3.
REQ-044 Protocol checks: count 32 scan_clk rising edges in each shift phase, exactly 1 scan_latch_en pulse, and scan_select high for exactly 2 cycles.
